// File: rtl/frame_buffer_ctrl.sv
// Frame capture / replay sequencer sitting directly on a single-port no-change RAM with
// a READ_LATENCY-cycle registered read path; a small skid FIFO hides that latency on replay.
module frame_buffer_ctrl #(
  parameter int RAM_WIDTH    = 18,
  parameter int RAM_DEPTH    = 1024,
  parameter int FRAME_LEN    = 1024,
  parameter int READ_LATENCY = 2,
  localparam int ADDR_W      = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1
) (
  input  logic                 clka,
  input  logic                 rsta_n,
  input  logic                 start_wr,
  input  logic                 start_rd,
  input  logic                 abort,
  input  logic [RAM_WIDTH-1:0] s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic [RAM_WIDTH-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 m_last,
  output logic                 busy,
  output logic                 wr_done,
  output logic                 rd_done,
  output logic [ADDR_W-1:0]    ram_addra,
  output logic [RAM_WIDTH-1:0] ram_dina,
  output logic                 ram_wea,
  output logic                 ram_ena,
  output logic                 ram_regcea,
  output logic                 ram_rsta,
  input  logic [RAM_WIDTH-1:0] ram_douta
);

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

  localparam int FIFO_D = READ_LATENCY + 1;
  localparam int PTR_W  = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
  localparam int FCNT_W = $clog2(FIFO_D + 1);
  localparam int CNT_W  = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] FRAME_END = CNT_W'(FRAME_LEN);
  localparam logic [PTR_W-1:0] PTR_MAX   = PTR_W'(FIFO_D - 1);

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        wr_addr_q, wr_addr_d;
  logic [CNT_W-1:0]        rd_addr_q, rd_addr_d;
  logic [CNT_W-1:0]        beat_cnt_q, beat_cnt_d;
  logic [READ_LATENCY-1:0] vld_q, vld_d;
  logic [PTR_W-1:0]        fwr_ptr_q, fwr_ptr_d;
  logic [PTR_W-1:0]        frd_ptr_q, frd_ptr_d;
  logic [FCNT_W-1:0]       fcnt_q, fcnt_d;
  logic                    wr_done_q, wr_done_d;
  logic                    rd_done_q, rd_done_d;
  logic [RAM_WIDTH-1:0]    fifo_mem_q [FIFO_D];

  logic wr_fire, issue, push, pop;
  int   inflight, occ;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_MAX) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      state_q    <= IDLE;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      beat_cnt_q <= '0;
      vld_q      <= '0;
      fwr_ptr_q  <= '0;
      frd_ptr_q  <= '0;
      fcnt_q     <= '0;
      wr_done_q  <= 1'b0;
      rd_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      beat_cnt_q <= beat_cnt_d;
      vld_q      <= vld_d;
      fwr_ptr_q  <= fwr_ptr_d;
      frd_ptr_q  <= frd_ptr_d;
      fcnt_q     <= fcnt_d;
      wr_done_q  <= wr_done_d;
      rd_done_q  <= rd_done_d;
    end
  end

  // Skid storage is data only; occupancy is tracked by the reset pointers/count.
  always_ff @(posedge clka) begin
    if (push) fifo_mem_q[fwr_ptr_q] <= ram_douta;
  end

  always_comb begin
    inflight = 0;
    for (int i = 0; i < READ_LATENCY; i++) inflight = inflight + int'(vld_q[i]);
    occ = inflight + int'(fcnt_q);

    s_ready = (state_q == WRITE) && !abort;
    wr_fire = s_valid && s_ready;
    m_valid = (state_q == READ) && (fcnt_q != '0) && !abort;
    pop     = m_valid && m_ready;
    m_data  = m_valid ? fifo_mem_q[frd_ptr_q] : '0;
    m_last  = m_valid && (beat_cnt_q == LAST_IDX);
    push    = (state_q == READ) && !abort && vld_q[READ_LATENCY-1];
    // A slot freed by this cycle's pop is reusable at once; keeps one beat per cycle.
    issue   = (state_q == READ) && !abort && (rd_addr_q < FRAME_END) &&
              (occ < FIFO_D + int'(pop));

    ram_ena    = wr_fire || issue;
    ram_wea    = wr_fire;
    ram_addra  = wr_fire ? ADDR_W'(wr_addr_q) : (issue ? ADDR_W'(rd_addr_q) : '0);
    ram_dina   = wr_fire ? s_data : '0;
    ram_regcea = 1'b1;
    ram_rsta   = 1'b0;
    busy       = (state_q != IDLE);
    wr_done    = wr_done_q;
    rd_done    = rd_done_q;
  end

  always_comb begin
    state_d    = state_q;
    wr_addr_d  = wr_addr_q;
    rd_addr_d  = rd_addr_q;
    beat_cnt_d = beat_cnt_q;
    vld_d      = vld_q;
    fwr_ptr_d  = fwr_ptr_q;
    frd_ptr_d  = frd_ptr_q;
    fcnt_d     = fcnt_q;
    wr_done_d  = 1'b0;
    rd_done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        wr_addr_d  = '0;
        rd_addr_d  = '0;
        beat_cnt_d = '0;
        vld_d      = '0;
        fwr_ptr_d  = '0;
        frd_ptr_d  = '0;
        fcnt_d     = '0;
        if (start_wr)      state_d = WRITE;
        else if (start_rd) state_d = READ;
      end
      WRITE: begin
        if (wr_fire) begin
          wr_addr_d = wr_addr_q + CNT_W'(1);
          if (wr_addr_q == LAST_IDX) begin
            wr_done_d = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      READ: begin
        vld_d[0] = issue;
        for (int i = 1; i < READ_LATENCY; i++) vld_d[i] = vld_q[i-1];
        if (issue) rd_addr_d = rd_addr_q + CNT_W'(1);
        if (push)  fwr_ptr_d = ptr_inc(fwr_ptr_q);
        if (pop) begin
          frd_ptr_d  = ptr_inc(frd_ptr_q);
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
          if (beat_cnt_q == LAST_IDX) begin
            rd_done_d = 1'b1;
            state_d   = IDLE;
          end
        end
        fcnt_d = fcnt_q + FCNT_W'(push) - FCNT_W'(pop);
      end
      default: state_d = IDLE;
    endcase

    // Abort discards everything in flight and suppresses any completion pulse.
    if (abort) begin
      state_d    = IDLE;
      wr_addr_d  = '0;
      rd_addr_d  = '0;
      beat_cnt_d = '0;
      vld_d      = '0;
      fwr_ptr_d  = '0;
      frd_ptr_d  = '0;
      fcnt_d     = '0;
      wr_done_d  = 1'b0;
      rd_done_d  = 1'b0;
    end
  end

endmodule
